// File: rtl/prom_ld_pkg.sv
// Shared constants for the PROM-to-FIFO parameter loader: the state encodings
// (also visible on LD_STATE) and the default word count.
package prom_ld_pkg;

    localparam logic [1:0] ST_CLR_FF = 2'b00;
    localparam logic [1:0] ST_REQ    = 2'b01;
    localparam logic [1:0] ST_WRITE  = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    localparam int NWORDS_DEF = 36;

endpackage

// File: rtl/prom_tmo_wdog.sv
// PROM read watchdog: counts enabled cycles since the last clear and flags expiry
// once the count reaches TMO_CYC. Only instantiated when PROM_TMO_EN is defined.
module prom_tmo_wdog #(
    parameter int TMO_CYC = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] tmo_cnt_q;
    logic [7:0] tmo_cnt_d;

    assign expired_o = (tmo_cnt_q == 8'(TMO_CYC));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (clr_i) begin
            tmo_cnt_d = '0;
        end else if (en_i && !expired_o) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: rtl/prom_param_loader.sv
// Copies NWORDS parameter words from the PROM read port into the parameter FIFO and
// then holds XFER_DONE. Optional PROM read timeout is enabled by defining PROM_TMO_EN.
module prom_param_loader
    import prom_ld_pkg::*;
#(
    parameter int                NWORDS    = NWORDS_DEF,
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TMO_CYC   = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              PROM_REQ,
    output logic [ADDR_W-1:0] PROM_ADDR,
    input  logic              PROM_DV,
    input  logic [DATA_W-1:0] PROM_DATA,
    input  logic              FF_FULL,
    output logic              FF_RST,
    output logic              FF_WE,
    output logic [DATA_W-1:0] FF_DIN,
    output logic              XFER_DONE,
    output logic              XFER_ERR,
    output logic [1:0]        LD_STATE
);

    logic [1:0]        state_q,     state_d;
    logic [7:0]        wcnt_q,      wcnt_d;
    logic              clr_cnt_q,   clr_cnt_d;
    logic [DATA_W-1:0] data_q,      data_d;

    logic              ff_rst_q,    ff_rst_d;
    logic              prom_req_q,  prom_req_d;
    logic [ADDR_W-1:0] prom_addr_q, prom_addr_d;
    logic              ff_we_q,     ff_we_d;
    logic [DATA_W-1:0] ff_din_q,    ff_din_d;
    logic              xfer_done_q, xfer_done_d;
    logic              tmo_expired;

`ifdef PROM_TMO_EN
    logic              xfer_err_q,  xfer_err_d;

    prom_tmo_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_wdog (
        .CLK       (CLK),
        .RST       (RST),
        .clr_i     (state_q != ST_REQ),
        .en_i      ((state_q == ST_REQ) && !PROM_DV),
        .expired_o (tmo_expired)
    );

    always_comb begin
        xfer_err_d = xfer_err_q;
        if (state_d == ST_CLR_FF) begin
            xfer_err_d = 1'b0;
        end else if ((state_q == ST_REQ) && (state_d == ST_DONE)) begin
            xfer_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            xfer_err_q <= 1'b0;
        end else begin
            xfer_err_q <= xfer_err_d;
        end
    end

    assign XFER_ERR = xfer_err_q;
`else
    logic unused_tmo_cfg;

    assign tmo_expired    = 1'b0;
    assign unused_tmo_cfg = ^TMO_CYC;
    assign XFER_ERR       = 1'b0;
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_CLR_FF;
            wcnt_q      <= '0;
            clr_cnt_q   <= 1'b0;
            data_q      <= '0;
            ff_rst_q    <= 1'b1;
            prom_req_q  <= 1'b0;
            prom_addr_q <= '0;
            ff_we_q     <= 1'b0;
            ff_din_q    <= '0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            clr_cnt_q   <= clr_cnt_d;
            data_q      <= data_d;
            ff_rst_q    <= ff_rst_d;
            prom_req_q  <= prom_req_d;
            prom_addr_q <= prom_addr_d;
            ff_we_q     <= ff_we_d;
            ff_din_q    <= ff_din_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        clr_cnt_d = 1'b0;
        data_d    = data_q;
        case (state_q)
            ST_CLR_FF: begin
                wcnt_d    = '0;
                clr_cnt_d = ~clr_cnt_q;
                if (clr_cnt_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A data-valid on the expiry cycle still wins over the timeout.
                if (PROM_DV) begin
                    data_d  = PROM_DATA;
                    state_d = ST_WRITE;
                end else if (tmo_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (!FF_FULL) begin
                    wcnt_d  = wcnt_q + 8'd1;
                    state_d = (wcnt_q == 8'(NWORDS - 1)) ? ST_DONE : ST_REQ;
                end
            end
            default: begin
                if (START) begin
                    state_d = ST_CLR_FF;
                end
            end
        endcase
    end

    // Moore outputs follow the next state so they line up with LD_STATE; the FIFO
    // strobe lands in the cycle after the accepted Write, sampled against FF_FULL there.
    always_comb begin
        ff_rst_d    = (state_d == ST_CLR_FF);
        prom_req_d  = (state_d == ST_REQ);
        prom_addr_d = (state_d == ST_REQ) ? (BASE_ADDR + ADDR_W'(wcnt_d)) : '0;
        ff_we_d     = (state_q == ST_WRITE) && !FF_FULL;
        ff_din_d    = ff_we_d ? data_q : ff_din_q;
        xfer_done_d = (state_d == ST_DONE);
    end

    assign PROM_REQ  = prom_req_q;
    assign PROM_ADDR = prom_addr_q;
    assign FF_RST    = ff_rst_q;
    assign FF_WE     = ff_we_q;
    assign FF_DIN    = ff_din_q;
    assign XFER_DONE = xfer_done_q;
    assign LD_STATE  = state_q;

endmodule

// File: tb/tb_prom_param_loader.sv
// Bench for prom_param_loader: a PROM responder and FIFO-full driver feed the DUT while
// every load is scored against the list of PROM words it should have copied.
module tb_prom_param_loader;

    localparam int NW  = 36;
    localparam int TMO = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        PROM_REQ;
    logic [7:0]  PROM_ADDR;
    logic        PROM_DV = 1'b0;
    logic [15:0] PROM_DATA = '0;
    logic        FF_FULL = 1'b0;
    logic        FF_RST;
    logic        FF_WE;
    logic [15:0] FF_DIN;
    logic        XFER_DONE;
    logic        XFER_ERR;
    logic [1:0]  LD_STATE;

    always #5 CLK = ~CLK;

    prom_param_loader #(
        .NWORDS    (NW),
        .ADDR_W    (8),
        .DATA_W    (16),
        .BASE_ADDR (8'h00),
        .TMO_CYC   (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .PROM_REQ  (PROM_REQ),
        .PROM_ADDR (PROM_ADDR),
        .PROM_DV   (PROM_DV),
        .PROM_DATA (PROM_DATA),
        .FF_FULL   (FF_FULL),
        .FF_RST    (FF_RST),
        .FF_WE     (FF_WE),
        .FF_DIN    (FF_DIN),
        .XFER_DONE (XFER_DONE),
        .XFER_ERR  (XFER_ERR),
        .LD_STATE  (LD_STATE)
    );

    typedef struct {
        string name;
        int    dly_max;
        bit    dly_fixed;
        int    full_pct;
        int    full_word;
        bit    noise_words;
        bit    noise_rand;
        int    exp_writes;
        int    exp_ffrst;
        int    exp_cycles;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [256];

    // Observations of the current load.
    int          wr_cnt;
    logic [15:0] wr_data [$];
    int          addr_log [$];
    int          ffrst_cnt, done_rise, busy, full_viol;
    logic        prev_full, prev_done;

    // Stimulus knobs.
    int dly_max = 0;
    bit dly_fixed = 1'b1;
    int cur_dly = 0;
    int wait_cnt = 0;
    int full_pct = 0;
    int full_word = -1;
    int full_left = 0;
    bit full_used = 1'b0;
    bit noise_words = 1'b0;
    bit noise_rand = 1'b0;
    bit n5 = 1'b0;
    bit n20 = 1'b0;
    int hold_word = -1;
    bit start_now = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    endtask

    task automatic clear_track();
        wr_cnt = 0;
        wr_data.delete();
        addr_log.delete();
        ffrst_cnt = 0;
        done_rise = 0;
        busy = 0;
        full_viol = 0;
        prev_full = FF_FULL;
        prev_done = XFER_DONE;
        full_used = 1'b0;
        full_left = 0;
        n5 = 1'b0;
        n20 = 1'b0;
        wait_cnt = 0;
        cur_dly = dly_fixed ? dly_max : int'($urandom_range(0, dly_max));
    endtask

    task automatic sample();
        if (FF_WE === 1'b1) begin
            wr_cnt++;
            wr_data.push_back(FF_DIN);
            if (prev_full) full_viol++;
        end
        if (FF_RST === 1'b1) ffrst_cnt++;
        if (XFER_DONE === 1'b1 && !prev_done) done_rise++;
        if (XFER_DONE !== 1'b1) busy++;
        prev_done = (XFER_DONE === 1'b1);
    endtask

    task automatic drive();
        if (PROM_REQ === 1'b1) begin
            if (int'(PROM_ADDR) == hold_word) begin
                PROM_DV   = 1'b0;
                PROM_DATA = 16'($urandom);
            end else if (wait_cnt >= cur_dly) begin
                PROM_DV   = 1'b1;
                PROM_DATA = mem[PROM_ADDR];
                addr_log.push_back(int'(PROM_ADDR));
                wait_cnt  = 0;
                cur_dly   = dly_fixed ? dly_max : int'($urandom_range(0, dly_max));
            end else begin
                PROM_DV   = 1'b0;
                PROM_DATA = 16'($urandom);
                wait_cnt++;
            end
        end else begin
            // Stray valids outside a request must not be captured.
            PROM_DV   = noise_rand && ($urandom_range(0, 3) == 0);
            PROM_DATA = 16'($urandom);
            wait_cnt  = 0;
        end

        if (full_left > 0) begin
            FF_FULL = 1'b1;
            full_left--;
        end else if (!full_used && full_word >= 0 && LD_STATE == 2'b10 && wr_cnt == full_word) begin
            FF_FULL   = 1'b1;
            full_left = 4;
            full_used = 1'b1;
        end else begin
            FF_FULL = ($urandom_range(0, 99) < full_pct);
        end
        prev_full = FF_FULL;

        START     = start_now;
        start_now = 1'b0;
        if (noise_words && !n5 && wr_cnt == 5) begin
            START = 1'b1;
            n5    = 1'b1;
        end
        if (noise_words && !n20 && wr_cnt == 20) begin
            START = 1'b1;
            n20   = 1'b1;
        end
        if (noise_rand && XFER_DONE !== 1'b1 && $urandom_range(0, 15) == 0) START = 1'b1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        sample();
        drive();
    endtask

    task automatic run_load(input string name, input int budget);
        int steps;
        steps = 0;
        while (XFER_DONE !== 1'b1 && steps < budget) begin
            step();
            steps++;
        end
        check({name, "_done_reached"}, XFER_DONE, 1);
    endtask

    task automatic start_reload(input string name);
        clear_track();
        start_now = 1'b1;
        step();
        step();
        check({name, "_done_fall"}, XFER_DONE, 0);
    endtask

    task automatic verify_load(input string name, input int exp_n, input logic exp_err,
                               input int exp_ffrst, input int exp_cycles);
        int bad_data;
        int bad_addr;
        int wr_after;
        bad_data = 0;
        bad_addr = 0;
        check({name, "_writes"}, wr_cnt, exp_n);
        for (int k = 0; k < wr_data.size() && k < exp_n; k++)
            if (wr_data[k] !== mem[k % 256]) bad_data++;
        check({name, "_data_bad"}, bad_data, 0);
        check({name, "_addr_cnt"}, addr_log.size(), exp_n);
        for (int k = 0; k < addr_log.size(); k++)
            if (addr_log[k] != k) bad_addr++;
        check({name, "_addr_bad"}, bad_addr, 0);
        check({name, "_ffrst_cycles"}, ffrst_cnt, exp_ffrst);
        check({name, "_we_while_full"}, full_viol, 0);
        check({name, "_err"}, XFER_ERR, exp_err);
        check({name, "_state_done"}, LD_STATE, 2'b11);
        if (exp_cycles >= 0) check({name, "_latency"}, busy, exp_cycles);
        wr_after = wr_cnt;
        repeat (8) step();
        check({name, "_done_rises"}, done_rise, 1);
        check({name, "_quiet_after"}, {wr_cnt - wr_after, 31'(0), XFER_DONE}, {32'd0, 31'(0), 1'b1});
    endtask

    localparam logic [30:0] RST_PATTERN = {1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00};

    vec_t vecs [6];

    initial begin
        #900000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{"zero_wait",  0, 1'b1,  0, -1, 1'b0, 1'b0, NW, 2, 2 + 2 * NW};
        vecs[1] = '{"full_w10",   0, 1'b1,  0, 10, 1'b0, 1'b0, NW, 2, 2 + 2 * NW + 5};
        vecs[2] = '{"reload_d3",  3, 1'b1,  0, -1, 1'b0, 1'b0, NW, 2, 2 + 5 * NW};
        vecs[3] = '{"start_ign",  0, 1'b1,  0, -1, 1'b1, 1'b0, NW, 2, 2 + 2 * NW};
        vecs[4] = '{"random_a",   3, 1'b0, 30, -1, 1'b0, 1'b1, NW, 2, -1};
        vecs[5] = '{"random_b",   2, 1'b0, 10, 17, 1'b1, 1'b1, NW, 2, -1};

        // Reset state, then the automatic load on release with a 3-cycle PROM.
        fill_mem();
        dly_max   = 3;
        dly_fixed = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs",
              {PROM_REQ, PROM_ADDR, FF_RST, FF_WE, FF_DIN, XFER_DONE, XFER_ERR, LD_STATE},
              RST_PATTERN);
        clear_track();
        RST = 1'b0;
        sample();
        drive();
        run_load("t1", 2000);
        verify_load("t1", NW, 1'b0, 2, 2 + 5 * NW);

        for (int v = 0; v < 6; v++) begin
            dly_max     = vecs[v].dly_max;
            dly_fixed   = vecs[v].dly_fixed;
            full_pct    = vecs[v].full_pct;
            full_word   = vecs[v].full_word;
            noise_words = vecs[v].noise_words;
            noise_rand  = vecs[v].noise_rand;
            fill_mem();
            start_reload(vecs[v].name);
            run_load(vecs[v].name, 4000);
            verify_load(vecs[v].name, vecs[v].exp_writes, 1'b0, vecs[v].exp_ffrst, vecs[v].exp_cycles);
        end

        // PROM never answers word 4.
        dly_max     = 0;
        dly_fixed   = 1'b1;
        full_pct    = 0;
        full_word   = -1;
        noise_words = 1'b0;
        noise_rand  = 1'b0;
        hold_word   = 4;
        fill_mem();
        start_reload("t5");
`ifdef PROM_TMO_EN
        run_load("t5", 1000);
        // Counter reaches TMO after TMO silent Req cycles; the exit happens on the next edge.
        verify_load("t5", 4, 1'b1, 2, 2 + 2 * 4 + TMO + 1);
        hold_word = -1;
        fill_mem();
        start_reload("t5_retry");
        check("t5_retry_err_clear", XFER_ERR, 0);
        run_load("t5_retry", 2000);
        verify_load("t5_retry", NW, 1'b0, 2, 2 + 2 * NW);
`else
        repeat (300) step();
        check("t5_req_held", PROM_REQ, 1);
        check("t5_addr_held", PROM_ADDR, 4);
        check("t5_not_done", {XFER_DONE, XFER_ERR}, 2'b00);
        check("t5_writes", wr_cnt, 4);
`endif

        // Reset in the middle of a load.
        hold_word = -1;
        dly_max   = 2;
        dly_fixed = 1'b0;
        fill_mem();
        if (XFER_DONE !== 1'b1) begin
            start_now = 1'b0;
        end
        clear_track();
        start_now = 1'b1;
        begin
            int steps;
            steps = 0;
            while (wr_cnt < 17 && steps < 3000) begin
                step();
                steps++;
            end
        end
        check("t6_reached_w17", wr_cnt, 17);
        RST     = 1'b1;
        PROM_DV = 1'b0;
        START   = 1'b0;
        FF_FULL = 1'b0;
        #1;
        check("t6_async_reset",
              {PROM_REQ, PROM_ADDR, FF_RST, FF_WE, FF_DIN, XFER_DONE, XFER_ERR, LD_STATE},
              RST_PATTERN);
        repeat (2) @(posedge CLK);
        #1;
        fill_mem();
        clear_track();
        RST = 1'b0;
        sample();
        drive();
        run_load("t6", 3000);
        verify_load("t6", NW, 1'b0, 2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
